hazard_forward_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core. It tracks destination-register tags for the EX, MEM and WB stages and registers the 2-bit operand-forwarding selects that drive the EX-stage 4:1 operand muxes. It also detects load-use hazards, inserting a one-cycle stall plus bubble, and applies branch-redirect kills. It sits beside the ID/EX pipeline register and is the sole source of the forwarding mux select lines.

---
 rtl/core_pkg.sv | 26 ++
 rtl/hazard_tag_stage.sv | 33 +++
 rtl/hazard_forward_unit.sv | 136 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared pipeline-hazard types and constants: forwarding select encodings,
// the per-stage destination tag, and the producer/consumer match test.
package core_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_RSVD = 2'b11;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } hz_tag_t;

    localparam int      HZ_TAG_W      = $bits(hz_tag_t);
    localparam hz_tag_t HZ_TAG_BUBBLE = '0;

    // x0 is hardwired to zero, so a write to it never produces a forwardable value.
    function automatic logic tag_match(input hz_tag_t prod, input logic [4:0] src,
                                       input logic use_src);
        return prod.valid & prod.reg_write & (prod.rd != 5'd0) & (prod.rd == src) & use_src;
    endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// One pipeline-stage destination tag: loads the upstream tag when enabled,
// otherwise collapses to a bubble. Resets to a bubble.
module hazard_tag_stage
    import core_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load,
    input  hz_tag_t tag_in,
    output hz_tag_t tag_out
);

    hz_tag_t tag_d;
    hz_tag_t tag_q;

    always_comb begin
        tag_d = HZ_TAG_BUBBLE;
        if (load) begin
            tag_d = tag_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= HZ_TAG_BUBBLE;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_out = tag_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// EX/MEM/WB destination tracking, registered operand-forward selects,
// load-use stall detection, branch-redirect kill and a saturating stall counter.
module hazard_forward_unit
    import core_pkg::*;
#(
    parameter int XLEN_CNT = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [4:0]          id_rd,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                ex_redirect,
    output logic                stall,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic [XLEN_CNT-1:0] stall_count
);

    localparam int N_STAGES = 3;

    hz_tag_t       id_tag;
    hz_tag_t       stage_in  [N_STAGES];
    hz_tag_t       stage_out [N_STAGES];
    logic [N_STAGES-1:0] stage_load;
    hz_tag_t       ex_tag;
    hz_tag_t       mem_tag;

    logic          load_use_hit;
    logic          stall_int;
    logic          ex_load;

    logic [1:0]    fwd_a_d, fwd_a_q;
    logic [1:0]    fwd_b_d, fwd_b_q;
    logic [XLEN_CNT-1:0] stall_count_d, stall_count_q;

    // Nearest producer wins; a load still in EX is covered by the stall instead.
    function automatic logic [1:0] fwd_select(input hz_tag_t ex_t, input hz_tag_t mem_t,
                                              input logic [4:0] src, input logic use_src);
        logic [1:0] sel;
        sel = FWD_RF;
        if (tag_match(ex_t, src, use_src) && !ex_t.mem_read) begin
            sel = FWD_MEM;
        end else if (tag_match(mem_t, src, use_src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        id_tag           = HZ_TAG_BUBBLE;
        id_tag.valid     = id_valid;
        id_tag.rd        = id_rd;
        id_tag.reg_write = id_reg_write;
        id_tag.mem_read  = id_mem_read;
    end

    // Stage 0 is EX (fed from ID, may bubble); MEM and WB always advance.
    genvar gi;
    generate
        for (gi = 0; gi < N_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_ex
                assign stage_in[gi]   = id_tag;
                assign stage_load[gi] = ex_load;
            end else begin : g_tail
                assign stage_in[gi]   = stage_out[gi-1];
                assign stage_load[gi] = 1'b1;
            end

            hazard_tag_stage u_tag (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (stage_load[gi]),
                .tag_in  (stage_in[gi]),
                .tag_out (stage_out[gi])
            );

            a_bubble_is_zero: assert property (@(posedge clk) disable iff (!rst_n)
                stage_out[gi].valid || (stage_out[gi] == HZ_TAG_BUBBLE));
        end
    endgenerate

    assign ex_tag  = stage_out[0];
    assign mem_tag = stage_out[1];

    // Redirect dominates: a killed ID instruction can never request a stall.
    always_comb begin
        load_use_hit = ex_tag.mem_read &
                       (tag_match(ex_tag, id_rs1, id_use_rs1) |
                        tag_match(ex_tag, id_rs2, id_use_rs2));
        stall_int    = id_valid & !ex_redirect & load_use_hit;
        ex_load      = id_valid & !stall_int & !ex_redirect;
    end

    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (ex_load) begin
            fwd_a_d = fwd_select(ex_tag, mem_tag, id_rs1, id_use_rs1);
            fwd_b_d = fwd_select(ex_tag, mem_tag, id_rs2, id_use_rs2);
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_int && (stall_count_q != {XLEN_CNT{1'b1}})) begin
            stall_count_d = stall_count_q + XLEN_CNT'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q       <= FWD_RF;
            fwd_b_q       <= FWD_RF;
            stall_count_q <= '0;
        end else begin
            fwd_a_q       <= fwd_a_d;
            fwd_b_q       <= fwd_b_d;
            stall_count_q <= stall_count_d;
        end
    end

    a_fwd_never_rsvd: assert property (@(posedge clk) disable iff (!rst_n)
        (fwd_a_q != FWD_RSVD) && (fwd_b_q != FWD_RSVD));

    assign stall       = stall_int;
    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench: each driven cycle pushes its expected outputs to a
// scoreboard queue; a negedge monitor pops and compares one entry per cycle.
module tb_hazard_forward_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         id_valid = 1'b0;
    logic [4:0]   id_rs1 = '0;
    logic [4:0]   id_rs2 = '0;
    logic         id_use_rs1 = 1'b0;
    logic         id_use_rs2 = 1'b0;
    logic [4:0]   id_rd = '0;
    logic         id_reg_write = 1'b0;
    logic         id_mem_read = 1'b0;
    logic         ex_redirect = 1'b0;
    logic         stall;
    logic [1:0]   fwd_a;
    logic [1:0]   fwd_b;
    logic [W-1:0] stall_count;

    always #5 clk = ~clk;

    hazard_forward_unit #(.XLEN_CNT(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .ex_redirect  (ex_redirect),
        .stall        (stall),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_count  (stall_count)
    );

    typedef struct {
        string        name;
        logic         stall;
        logic [1:0]   fa;
        logic [1:0]   fb;
        logic [W-1:0] cnt;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_cnt  = '0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "stall",       32'(stall),       32'(e.stall));
            chk(e.name, "fwd_a",       32'(fwd_a),       32'(e.fa));
            chk(e.name, "fwd_b",       32'(fwd_b),       32'(e.fb));
            chk(e.name, "stall_count", 32'(stall_count), 32'(e.cnt));
            $display("cyc %-10s stall=%0b fwd_a=%02b fwd_b=%02b cnt=%0d", e.name,
                     stall, fwd_a, fwd_b, stall_count);
        end
    end

    task automatic push_exp(input string nm, input logic es, input logic [1:0] efa,
                            input logic [1:0] efb);
        exp_t e;
        e.name  = nm;
        e.stall = es;
        e.fa    = efa;
        e.fb    = efb;
        e.cnt   = exp_cnt;
        sb.push_back(e);
        if (es && (exp_cnt != {W{1'b1}})) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic rdr);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        ex_redirect  = rdr;
    endtask

    task automatic step(input string nm, input logic v, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic rdr, input logic es, input logic [1:0] efa,
                        input logic [1:0] efb);
        @(posedge clk);
        #1;
        drive(v, rs1, rs2, u1, u2, rd, rw, mr, rdr);
        push_exp(nm, es, efa, efb);
    endtask

    task automatic alu(input string nm, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic es, input logic [1:0] efa,
                       input logic [1:0] efb);
        step(nm, 1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, es, efa, efb);
    endtask

    task automatic ld(input string nm, input logic [4:0] rs1, input logic [4:0] rd,
                      input logic [1:0] efa, input logic [1:0] efb);
        step(nm, 1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0, efa, efb);
    endtask

    task automatic nop(input string nm, input logic [1:0] efa, input logic [1:0] efb);
        step(nm, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, efa, efb);
    endtask

    initial begin
        // Reset values while held in reset.
        nop("reset", 2'b00, 2'b00);
        rst_n = 1'b1;

        // EX->EX forward: add x5 ; sub x6,x5,x3
        alu("add_x5",  5'd1, 5'd2, 5'd5, 1'b0, 2'b00, 2'b00);
        alu("sub_x6",  5'd5, 5'd3, 5'd6, 1'b0, 2'b00, 2'b00);
        nop("sub_ex",  2'b10, 2'b00);

        // MEM->EX forward on rs2 with one independent instruction between.
        alu("prod_x5", 5'd1, 5'd2, 5'd5, 1'b0, 2'b00, 2'b00);
        alu("indep",   5'd11, 5'd12, 5'd10, 1'b0, 2'b00, 2'b00);
        alu("cons_rs2", 5'd4, 5'd5, 5'd13, 1'b0, 2'b00, 2'b00);
        nop("rs2_ex",  2'b00, 2'b01);

        // Load-use: one stall, bubble has fwd 00, retry forwards from WB.
        ld ("lw_x7",   5'd1, 5'd7, 2'b00, 2'b00);
        alu("lu_stall", 5'd7, 5'd7, 5'd8, 1'b1, 2'b00, 2'b00);
        alu("lu_retry", 5'd7, 5'd7, 5'd8, 1'b0, 2'b00, 2'b00);
        nop("lu_ex",   2'b01, 2'b01);

        // x0 never forwards; nearest of two x9 producers wins.
        step("wr_x0", 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        alu("rd_x0",   5'd0, 5'd0, 5'd14, 1'b0, 2'b00, 2'b00);
        alu("x9_a",    5'd1, 5'd2, 5'd9, 1'b0, 2'b00, 2'b00);
        alu("x9_b",    5'd3, 5'd4, 5'd9, 1'b0, 2'b00, 2'b00);
        alu("cons_x9", 5'd9, 5'd6, 5'd15, 1'b0, 2'b00, 2'b00);
        nop("x9_ex",   2'b10, 2'b00);

        // Redirect coincident with load-use: no stall, bubble, count unchanged.
        ld ("lw_rd",   5'd1, 5'd7, 2'b00, 2'b00);
        step("lu_redir", 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        nop("redir_ex", 2'b00, 2'b00);

        // A killed producer must not be forwarded.
        step("kill_x5", 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        alu("cons_kill", 5'd5, 5'd5, 5'd16, 1'b0, 2'b00, 2'b00);
        nop("kill_ex", 2'b00, 2'b00);

        // 17 more load-use stalls drive the 4-bit counter past saturation.
        for (int k = 0; k < 17; k++) begin
            ld ("sat_lw", 5'd1, 5'd7, (k == 0) ? 2'b00 : 2'b01, (k == 0) ? 2'b00 : 2'b01);
            alu("sat_stl", 5'd7, 5'd7, 5'd8, 1'b1, 2'b00, 2'b00);
            alu("sat_rty", 5'd7, 5'd7, 5'd8, 1'b0, 2'b00, 2'b00);
        end

        // Reset in the middle of a stall while fwd_a holds 10.
        alu("pre_x5",  5'd1, 5'd2, 5'd5, 1'b0, 2'b01, 2'b01);
        ld ("lw_x5",   5'd5, 5'd7, 2'b00, 2'b00);
        @(posedge clk);
        #1;
        drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        rst_n   = 1'b0;
        exp_cnt = '0;
        push_exp("rst_mid", 1'b0, 2'b00, 2'b00);
        nop("rst_hold", 2'b00, 2'b00);
        rst_n = 1'b1;

        // Pipeline works again after reset.
        alu("post_add", 5'd1, 5'd2, 5'd5, 1'b0, 2'b00, 2'b00);
        alu("post_sub", 5'd5, 5'd3, 5'd6, 1'b0, 2'b00, 2'b00);
        nop("post_ex",  2'b10, 2'b00);

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #1;
        chk("drain", "pending", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
